// File: rtl/display_scan_driver_if.sv
// display_scan_driver_if: bundle between the scan driver, the digit mux and the display pins.
interface display_scan_driver_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             lzb_en;
   logic [WIDTH-1:0] digit_in;
   logic [1:0]       sel;
   logic [3:0]       an;
   logic [6:0]       seg;
   logic             frame_tick;
   modport master (input en, lzb_en, digit_in, output sel, an, seg, frame_tick);
   modport slave (output en, lzb_en, digit_in, input sel, an, seg, frame_tick);
endinterface

// File: rtl/display_scan_driver.sv
// display_scan_driver: 4-digit 7-segment scan driver with per-digit blanking dead-time
// and optional leading-zero blanking; scans MSD (sel=3) first.
module display_scan_driver #(
   parameter int WIDTH = 4,
   parameter int DWELL = 1000,
   parameter int BLANK = 16,
   parameter int ACTIVE_LOW_SEG = 1
) (
   input logic clk,
   input logic rst_n,
   display_scan_driver_if.master bus
);
   localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [6:0] SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
   // active-high {g,f,e,d,c,b,a} glyphs for hex 0-F
   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };
   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      sel_q, sel_d;
   logic [3:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic            tick_q, tick_d;
   logic            zr_q, zr_d;
   logic [WIDTH-1:0] digit;
   logic [6:0]      glyph_lvl;
   logic            lead_zero;
   assign digit = bus.digit_in;
   assign glyph_lvl = (ACTIVE_LOW_SEG != 0) ? ~GLYPH[digit[3:0]] : GLYPH[digit[3:0]];
   assign lead_zero = bus.lzb_en && (sel_q != 2'd0) && zr_q && (digit[3:0] == 4'd0);
   assign bus.sel = sel_q;
   assign bus.an = an_q;
   assign bus.seg = seg_q;
   assign bus.frame_tick = tick_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         sel_q <= 2'd3;
         an_q <= 4'hF;
         seg_q <= SEG_OFF;
         tick_q <= 1'b0;
         zr_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         sel_q <= sel_d;
         an_q <= an_d;
         seg_q <= seg_d;
         tick_q <= tick_d;
         zr_q <= zr_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      sel_d = sel_q;
      an_d = an_q;
      seg_d = seg_q;
      tick_d = 1'b0;
      zr_d = zr_q;
      if (!bus.en) begin
         state_d = S_IDLE;
         cnt_d = '0;
         sel_d = 2'd3;
         an_d = 4'hF;
         seg_d = SEG_OFF;
         zr_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_BLANK;
               cnt_d = '0;
               zr_d = 1'b1;
            end
            S_BLANK: begin
               cnt_d = (cnt_q == BLANK_LAST) ? '0 : cnt_q + 1'b1;
               if (cnt_q == BLANK_LAST) begin
                  state_d = S_SHOW;
                  an_d = ~(4'b0001 << sel_q);
                  seg_d = lead_zero ? SEG_OFF : glyph_lvl;
                  zr_d = lead_zero;
               end
            end
            S_SHOW: begin
               cnt_d = (cnt_q == DWELL_LAST) ? '0 : cnt_q + 1'b1;
               // wrapping back to the MSD re-arms the leading-zero run
               if (cnt_q == DWELL_LAST) begin
                  state_d = S_BLANK;
                  sel_d = sel_q - 2'd1;
                  an_d = 4'hF;
                  tick_d = (sel_q == 2'd0);
                  zr_d = zr_q | (sel_q == 2'd0);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver: directed and randomized checks of the scan driver with DWELL=4, BLANK=2.
module tb_display_scan_driver;
   localparam int DWELL = 4;
   localparam int BLANK = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   logic [3:0] d [4];
   display_scan_driver_if #(.WIDTH(4)) bus ();
   display_scan_driver #(.WIDTH(4), .DWELL(DWELL), .BLANK(BLANK), .ACTIVE_LOW_SEG(1)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   assign bus.digit_in = d[bus.sel];
   // active-low common-anode patterns {g,f,e,d,c,b,a}
   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction
   task automatic restart();
      @(negedge clk);
      bus.en = 1'b0;
      @(negedge clk);
      bus.en = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_reset();
      rst_n = 1'b0;
      bus.en = 1'b0;
      bus.lzb_en = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++; if (bus.an !== 4'hF) begin n_fail++; $display("FAIL reset_an got %h exp f", bus.an); end
      n_chk++; if (bus.sel !== 2'd3) begin n_fail++; $display("FAIL reset_sel got %0d exp 3", bus.sel); end
      n_chk++; if (bus.seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %h exp 7f", bus.seg); end
      n_chk++; if (bus.frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b exp 0", bus.frame_tick); end
   endtask
   task automatic test_scan();
      int p, idx, q;
      logic [3:0] ea;
      d = '{4, 3, 2, 1};
      @(negedge clk);
      rst_n = 1'b1;
      bus.en = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 50; k++) begin
         p = k % 24;
         idx = 3 - p / 6;
         q = p % 6;
         ea = (q < BLANK) ? 4'hF : ~(4'b0001 << idx);
         n_chk++; if (bus.sel !== 2'(idx)) begin n_fail++; $display("FAIL scan_sel k=%0d got %0d exp %0d", k, bus.sel, idx); end
         n_chk++; if (bus.an !== ea) begin n_fail++; $display("FAIL scan_an k=%0d got %h exp %h", k, bus.an, ea); end
         n_chk++; if (bus.frame_tick !== (k > 0 && p == 0)) begin n_fail++; $display("FAIL scan_tick k=%0d got %b", k, bus.frame_tick); end
         if (q >= BLANK) begin
            n_chk++; if (bus.seg !== glyph(4'(4 - idx))) begin n_fail++; $display("FAIL scan_seg k=%0d got %h exp %h", k, bus.seg, glyph(4'(4 - idx))); end
         end
         @(negedge clk);
      end
   endtask
   task automatic test_lzb(input logic lzb, input logic [15:0] digits, input logic [27:0] exp_seg);
      int idx, q;
      d[3] = digits[15:12];
      d[2] = digits[11:8];
      d[1] = digits[7:4];
      d[0] = digits[3:0];
      bus.lzb_en = lzb;
      restart();
      for (int k = 0; k < 24; k++) begin
         idx = 3 - k / 6;
         q = k % 6;
         if (q >= BLANK) begin
            n_chk++; if (bus.an !== ~(4'b0001 << idx)) begin n_fail++; $display("FAIL lzb_an digits=%h k=%0d got %h", digits, k, bus.an); end
            n_chk++; if (bus.seg !== exp_seg[idx*7 +: 7]) begin n_fail++; $display("FAIL lzb_seg lzb=%b digits=%h k=%0d got %h exp %h", lzb, digits, k, bus.seg, exp_seg[idx*7 +: 7]); end
         end
         @(negedge clk);
      end
      bus.lzb_en = 1'b0;
   endtask
   task automatic test_en_drop();
      d = '{4, 3, 2, 1};
      restart();
      repeat (9) @(negedge clk);
      n_chk++; if (bus.an !== 4'b1011) begin n_fail++; $display("FAIL drop_pre_an got %h exp b", bus.an); end
      bus.en = 1'b0;
      @(negedge clk);
      n_chk++; if (bus.an !== 4'hF) begin n_fail++; $display("FAIL drop_an got %h exp f", bus.an); end
      n_chk++; if (bus.seg !== 7'h7F) begin n_fail++; $display("FAIL drop_seg got %h exp 7f", bus.seg); end
      n_chk++; if (bus.sel !== 2'd3) begin n_fail++; $display("FAIL drop_sel got %0d exp 3", bus.sel); end
      n_chk++; if (bus.frame_tick !== 1'b0) begin n_fail++; $display("FAIL drop_tick got %b exp 0", bus.frame_tick); end
      bus.en = 1'b1;
      repeat (2) begin
         @(negedge clk);
         n_chk++; if (bus.an !== 4'hF || bus.sel !== 2'd3) begin n_fail++; $display("FAIL resume_blank an=%h sel=%0d exp f/3", bus.an, bus.sel); end
      end
      @(negedge clk);
      n_chk++; if (bus.an !== 4'b0111) begin n_fail++; $display("FAIL resume_an got %h exp 7", bus.an); end
      n_chk++; if (bus.seg !== 7'h79) begin n_fail++; $display("FAIL resume_seg got %h exp 79", bus.seg); end
      restart();
      repeat (23) @(negedge clk);
      bus.en = 1'b0;
      @(negedge clk);
      n_chk++; if (bus.frame_tick !== 1'b0 || bus.an !== 4'hF) begin n_fail++; $display("FAIL partial_tick tick=%b an=%h exp 0/f", bus.frame_tick, bus.an); end
      bus.en = 1'b1;
   endtask
   task automatic test_async_reset();
      d = '{4, 3, 2, 1};
      restart();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (bus.an !== 4'hF) begin n_fail++; $display("FAIL arst_an got %h exp f", bus.an); end
      n_chk++; if (bus.seg !== 7'h7F) begin n_fail++; $display("FAIL arst_seg got %h exp 7f", bus.seg); end
      n_chk++; if (bus.sel !== 2'd3) begin n_fail++; $display("FAIL arst_sel got %0d exp 3", bus.sel); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++; if (bus.an !== 4'hF) begin n_fail++; $display("FAIL arst_resume_blank got %h exp f", bus.an); end
      repeat (2) @(negedge clk);
      n_chk++; if (bus.an !== 4'b0111 || bus.seg !== 7'h79) begin n_fail++; $display("FAIL arst_resume_show an=%h seg=%h exp 7/79", bus.an, bus.seg); end
   endtask
   task automatic test_random();
      logic [3:0] step, v, prev_an;
      logic [15:0] hit;
      logic [1:0] nxt;
      logic prev_en;
      int blank_run, low_run;
      step = 4'(2 * $urandom_range(0, 7) + 1);
      v = 4'd0;
      hit = '0;
      blank_run = 0;
      low_run = 0;
      prev_an = 4'hF;
      prev_en = 1'b1;
      bus.lzb_en = 1'b0;
      restart();
      for (int c = 0; c < 480; c++) begin
         if (!prev_en) begin
            n_chk++; if (bus.an !== 4'hF || bus.frame_tick !== 1'b0) begin n_fail++; $display("FAIL rnd_idle c=%0d an=%h tick=%b", c, bus.an, bus.frame_tick); end
         end
         n_chk++; if ($countones(~bus.an) > 1) begin n_fail++; $display("FAIL rnd_overlap c=%0d an=%h", c, bus.an); end
         if (bus.an !== 4'hF) begin
            n_chk++; if (bus.an !== ~(4'b0001 << bus.sel)) begin n_fail++; $display("FAIL rnd_an_sel c=%0d an=%h sel=%0d", c, bus.an, bus.sel); end
            n_chk++; if (bus.seg !== glyph(d[bus.sel])) begin n_fail++; $display("FAIL rnd_seg c=%0d got %h exp %h", c, bus.seg, glyph(d[bus.sel])); end
            if (prev_an === 4'hF) begin
               n_chk++; if (blank_run < BLANK) begin n_fail++; $display("FAIL rnd_blank_len c=%0d got %0d exp >=%0d", c, blank_run, BLANK); end
               nxt = bus.sel - 2'd1;
               d[nxt] = v;
               v = v + step;
            end
            hit[d[bus.sel]] = 1'b1;
            low_run++;
            blank_run = 0;
            n_chk++; if (low_run > DWELL) begin n_fail++; $display("FAIL rnd_dwell c=%0d got %0d exp <=%0d", c, low_run, DWELL); end
         end else begin
            blank_run++;
            low_run = 0;
         end
         prev_an = bus.an;
         bus.en = ($urandom_range(0, 79) != 0);
         prev_en = bus.en;
         @(negedge clk);
      end
      n_chk++; if (hit !== 16'hFFFF) begin n_fail++; $display("FAIL rnd_coverage got %h exp ffff", hit); end
      bus.en = 1'b1;
   endtask
   initial begin
      bus.en = 1'b0;
      bus.lzb_en = 1'b0;
      d = '{0, 0, 0, 0};
      test_reset();
      test_scan();
      test_lzb(1'b1, 16'h0050, {7'h7F, 7'h7F, 7'h12, 7'h40});
      test_lzb(1'b0, 16'h0050, {7'h40, 7'h40, 7'h12, 7'h40});
      test_lzb(1'b1, 16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40});
      test_lzb(1'b1, 16'h0500, {7'h7F, 7'h12, 7'h40, 7'h40});
      test_en_drop();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
